// File: rtl/uns_add_256_ctrl_pkg.sv
// Shared types and defaults for the 256-bit slice-serial adder sequencer.
package uns_add_256_ctrl_pkg;

  localparam int WORDS_DEF = 16;
  localparam int CW_DEF    = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    ADD    = 3'd3,
    FIN    = 3'd4,
    OUT    = 3'd5
  } state_t;

endpackage

// File: rtl/uns_add_beat_cnt.sv
// Beat counter shared by all sequencer phases; clr has priority over inc.
module uns_add_beat_cnt
  import uns_add_256_ctrl_pkg::*;
#(
  parameter int WORDS = WORDS_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign last = (cnt == CW'(WORDS - 1));

endmodule

// File: rtl/uns_add_256_ctrl.sv
// Sequencer for the 256-bit slice-serial unsigned adder datapath.
// Optional macro UNS_ADD_256_CTRL_KEEP_A_EN adds keep_a to reuse operand A.
module uns_add_256_ctrl
  import uns_add_256_ctrl_pkg::*;
#(
  parameter int WORDS = WORDS_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
`ifdef UNS_ADD_256_CTRL_KEEP_A_EN
  input  logic keep_a,
`endif
  output logic busy,
  output logic done,
  input  logic in_valid,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic out_last,
  input  logic carry_in,
  output logic result_carry,
  output logic rega_we,
  output logic regb_we,
  output logic regs_we,
  output logic rega_sel_cyc,
  output logic regb_sel_cyc,
  output logic regs_sel_cyc,
  output logic dff_we,
  output logic carry_clr
);

  state_t        state, next_state;
  logic          cnt_inc, cnt_clr, cnt_last;
  logic [CW-1:0] cnt;
  logic          done_r, rc_r;
  logic          skip_a;

`ifdef UNS_ADD_256_CTRL_KEEP_A_EN
  assign skip_a = keep_a;
`else
  assign skip_a = 1'b0;
`endif

  uns_add_beat_cnt #(.WORDS(WORDS), .CW(CW)) u_beat_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (cnt_inc),
    .clr  (cnt_clr),
    .cnt  (cnt),
    .last (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      done_r <= 1'b0;
      rc_r   <= 1'b0;
    end else begin
      state  <= next_state;
      done_r <= (state == OUT) && (next_state == IDLE);
      if (state == FIN) begin
        rc_r <= carry_in;
      end
    end
  end

  always_comb begin
    next_state = state;
    cnt_inc    = 1'b0;
    case (state)
      IDLE:   if (start) next_state = skip_a ? LOAD_B : LOAD_A;
      LOAD_A: if (in_valid) begin
        cnt_inc = 1'b1;
        if (cnt_last) next_state = LOAD_B;
      end
      LOAD_B: if (in_valid) begin
        cnt_inc = 1'b1;
        if (cnt_last) next_state = ADD;
      end
      ADD: begin
        cnt_inc = 1'b1;
        if (cnt_last) next_state = FIN;
      end
      FIN:    next_state = OUT;
      OUT:    if (out_ready) begin
        cnt_inc = 1'b1;
        if (cnt_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Every phase starts counting from beat 0.
  assign cnt_clr = (next_state != state);

  always_comb begin
    rega_we      = 1'b0;
    regb_we      = 1'b0;
    regs_we      = 1'b0;
    rega_sel_cyc = 1'b0;
    regb_sel_cyc = 1'b0;
    regs_sel_cyc = 1'b0;
    dff_we       = 1'b0;
    carry_clr    = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (state)
      IDLE:   carry_clr = start;
      LOAD_A: begin
        in_ready = 1'b1;
        rega_we  = in_valid;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        regb_we  = in_valid;
      end
      ADD: begin
        rega_we      = 1'b1;
        regb_we      = 1'b1;
        rega_sel_cyc = 1'b1;
        regb_sel_cyc = 1'b1;
        dff_we       = 1'b1;
        regs_we      = 1'b1;
      end
      OUT: begin
        out_valid    = 1'b1;
        regs_we      = out_ready;
        regs_sel_cyc = out_ready;
      end
      default: ;
    endcase
  end

  assign busy         = (state != IDLE);
  assign done         = done_r;
  assign out_last     = (state == OUT) && cnt_last;
  assign result_carry = rc_r;

endmodule

// File: tb/tb_uns_add_256_ctrl.sv
// Bench for uns_add_256_ctrl: a behavioural datapath driven by the strobes,
// with results checked against plain 257-bit addition.
module tb_uns_add_256_ctrl;

  logic clk = 1'b0;
  logic rst, start, keep_a, in_valid, out_ready, carry_in;
  logic busy, done, in_ready, out_valid, out_last, result_carry;
  logic rega_we, regb_we, regs_we, rega_sel_cyc, regb_sel_cyc, regs_sel_cyc;
  logic dff_we, carry_clr;
  logic [15:0] datain;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uns_add_256_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
`ifdef UNS_ADD_256_CTRL_KEEP_A_EN
    .keep_a       (keep_a),
`endif
    .busy         (busy),
    .done         (done),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .carry_in     (carry_in),
    .result_carry (result_carry),
    .rega_we      (rega_we),
    .regb_we      (regb_we),
    .regs_we      (regs_we),
    .rega_sel_cyc (rega_sel_cyc),
    .regb_sel_cyc (regb_sel_cyc),
    .regs_sel_cyc (regs_sel_cyc),
    .dff_we       (dff_we),
    .carry_clr    (carry_clr)
  );

  // Behavioural datapath: cyclic word registers, 16-bit slice and carry flop.
  logic [15:0] ra [16];
  logic [15:0] rb [16];
  logic [15:0] rs [16];
  logic        cf = 1'b0;
  logic [16:0] slice;

  assign slice    = {1'b0, ra[0]} + {1'b0, rb[0]} + {16'd0, cf};
  assign carry_in = cf;

  always @(posedge clk) begin
    if (rega_we) begin
      for (int i = 0; i < 15; i++) ra[i] <= ra[i+1];
      ra[15] <= rega_sel_cyc ? ra[0] : datain;
    end
    if (regb_we) begin
      for (int i = 0; i < 15; i++) rb[i] <= rb[i+1];
      rb[15] <= regb_sel_cyc ? rb[0] : datain;
    end
    if (regs_we) begin
      for (int i = 0; i < 15; i++) rs[i] <= rs[i+1];
      rs[15] <= regs_sel_cyc ? rs[0] : slice[15:0];
    end
    if (carry_clr)   cf <= 1'b0;
    else if (dff_we) cf <= slice[16];
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [255:0] rep16(input logic [15:0] w);
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[16*i +: 16] = w;
    return v;
  endfunction

  function automatic logic [7:0] strobes();
    return {rega_we, regb_we, regs_we, rega_sel_cyc, regb_sel_cyc, regs_sel_cyc, dff_we, carry_clr};
  endfunction

  // One complete operation. abort_add>0 resets the DUT in that ADD cycle.
  task automatic run_op(input logic [255:0] a, input logic [255:0] b, input bit keep,
                        input int vld_pct, input int rdy_pct, input bit spur,
                        input int start_len, input int abort_add, input int exp_cycles);
    logic [15:0]  q[$];
    logic [256:0] ref_sum;
    logic [255:0] got;
    int  cyc, add_n, add_first, add_last, clr_n, a_loads, b_loads, out_idx, rdy_n;
    bit  seen_done, aborted, prev_stall;
    logic        prev_last;
    logic [15:0] prev_w;

    ref_sum = {1'b0, a} + {1'b0, b};
    got = '0;
    cyc = 0; add_n = 0; add_first = -1; add_last = -1; clr_n = 0;
    a_loads = 0; b_loads = 0; out_idx = 0; rdy_n = 0;
    seen_done = 0; aborted = 0; prev_stall = 0; prev_last = 0; prev_w = '0;
    if (!keep) for (int i = 0; i < 16; i++) q.push_back(a[16*i +: 16]);
    for (int i = 0; i < 16; i++) q.push_back(b[16*i +: 16]);

    while (!seen_done && !aborted && cyc < 3000) begin
      @(negedge clk);
      if (cyc < start_len) start = 1'b1;
      else start = spur && busy && ($urandom_range(0, 3) == 0);
      keep_a    = keep;
      in_valid  = (q.size() > 0) ? ($urandom_range(0, 99) < vld_pct)
                                 : (spur && ($urandom_range(0, 1) == 1));
      datain    = (q.size() > 0) ? q[0] : 16'($urandom);
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      #1;
      if (carry_clr) clr_n++;
      if (rega_we && !rega_sel_cyc) a_loads++;
      if (regb_we && !regb_sel_cyc) b_loads++;
      if (in_ready) rdy_n++;
      if (in_ready && in_valid) begin
        chk("load_one_reg", 256'(rega_we ^ regb_we), 256'(1));
        chk("load_sel", 256'({rega_sel_cyc, regb_sel_cyc}), 256'(0));
        void'(q.pop_front());
      end
      if (in_ready && !in_valid) chk("load_stall_en", 256'({rega_we, regb_we, regs_we, dff_we}), 256'(0));
      if (!in_ready && !dff_we) chk("ab_idle", 256'({rega_we, regb_we}), 256'(0));
      if (dff_we) begin
        chk("add_strobes", 256'(strobes()), 256'(8'b1111_1010));
        if (add_first < 0) add_first = cyc;
        add_last = cyc;
        add_n++;
        if (abort_add > 0 && add_n == abort_add) aborted = 1;
      end
      if (out_valid && !out_ready) begin
        chk("out_stall_en", 256'(strobes()), 256'(0));
        if (prev_stall) begin
          chk("out_last_stable", 256'(out_last), 256'(prev_last));
          chk("out_word_stable", 256'(rs[0]), 256'(prev_w));
        end
      end
      if (out_valid && out_ready) begin
        chk("out_last", 256'(out_last), 256'(out_idx == 15));
        chk("out_rotate", 256'({regs_we, regs_sel_cyc}), 256'(2'b11));
        if (out_idx < 16) got[16*out_idx +: 16] = rs[0];
        out_idx++;
      end
      prev_stall = out_valid && !out_ready;
      prev_last  = out_last;
      prev_w     = rs[0];
      if (done) begin
        seen_done = 1;
        chk("done_busy", 256'(busy), 256'(0));
        if (exp_cycles >= 0) chk("latency", 256'(cyc), 256'(exp_cycles));
      end
      cyc++;
    end

    if (aborted) begin
      rst = 1'b1;
      #1;
      chk("abort_busy", 256'(busy), 256'(0));
      chk("abort_done", 256'(done), 256'(0));
      chk("abort_strobes", 256'({strobes(), in_ready, out_valid}), 256'(0));
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        #1;
        chk("abort_quiet", 256'({done, busy}), 256'(0));
      end
    end else begin
      chk("finished", 256'(seen_done), 256'(1));
      chk("sum", got, ref_sum[255:0]);
      chk("result_carry", 256'(result_carry), 256'(ref_sum[256]));
      chk("add_len", 256'(add_n), 256'(16));
      chk("add_contig", 256'(add_last - add_first), 256'(15));
      chk("carry_clr_once", 256'(clr_n), 256'(1));
      chk("a_loads", 256'(a_loads), 256'(keep ? 0 : 16));
      chk("b_loads", 256'(b_loads), 256'(16));
      if (vld_pct >= 100) chk("in_ready_cycles", 256'(rdy_n), 256'(keep ? 16 : 32));
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      #1;
      chk("done_pulse", 256'(done), 256'(0));
      chk("carry_hold", 256'(result_carry), 256'(ref_sum[256]));
    end
  endtask

  initial begin
    logic [255:0] ra_v, rb_v;
    rst = 1'b1; start = 1'b0; keep_a = 1'b0; in_valid = 1'b0; out_ready = 1'b0; datain = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_flags", 256'({busy, done, in_ready, out_valid, out_last, result_carry}), 256'(0));
    chk("reset_strobes", 256'(strobes()), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_flags", 256'({busy, done, in_ready, out_valid, out_last}), 256'(0));

    run_op({256{1'b1}}, 256'd1, 1'b0, 100, 100, 1'b0, 1, 0, 66);
    run_op(rep16(16'h1234), rep16(16'h0001), 1'b0, 100, 100, 1'b0, 1, 0, 66);

    ra_v = rand256(); rb_v = rand256();
    run_op(ra_v, rb_v, 1'b0, 100, 100, 1'b0, 1, 0, 66);
    run_op(ra_v, rb_v, 1'b0, 60, 50, 1'b0, 1, 0, -1);

    run_op(rand256(), rand256(), 1'b0, 70, 50, 1'b1, 2, 0, -1);
    run_op(rand256(), rand256(), 1'b0, 100, 100, 1'b0, 1, 7, -1);
    run_op(rand256(), rand256(), 1'b0, 80, 60, 1'b0, 1, 0, -1);

`ifdef UNS_ADD_256_CTRL_KEEP_A_EN
    run_op({256{1'b1}}, 256'd1, 1'b0, 100, 100, 1'b0, 1, 0, 66);
    run_op({256{1'b1}}, 256'd2, 1'b1, 100, 100, 1'b0, 1, 0, 50);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
